// File: rtl/uart_boot_loader.sv
// uart_boot_loader
//   Receives a program image over an 8N1 UART line (LSB first, idle high) and
//   writes it word by word into instruction memory. The MIPS core is held in
//   reset until the whole image has been written.
//   Image format (big-endian): 16-bit word count N, then N 32-bit words,
//   most significant byte first.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per UART bit (>= 4)
//   ADDR_W        instruction-memory word-address width (<= 16)
//
// Ports
//   clk         system clock
//   rst         asynchronous active-high reset
//   rx          UART serial input
//   imem_we     one-cycle instruction-memory write strobe
//   imem_addr   word address of the write
//   imem_wdata  word to write
//   cpu_rst     reset to the MIPS core, high while loading
//   boot_done   level, image fully loaded
//   frame_err   one-cycle pulse when a stop bit samples 0
module uart_boot_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              boot_done,
  output logic              frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  // ---------------------------------------------------------------- rx sync
  logic rx_meta, rxs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // ---------------------------------------------------------------- RX FSM
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t       rx_st, rx_st_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      bit_i, bit_i_n;
  logic [7:0]      rx_sh, rx_sh_n;
  logic            byte_valid;
  logic            stop_bad;

  always_comb begin
    rx_st_n    = rx_st;
    cnt_n      = cnt;
    bit_i_n    = bit_i;
    rx_sh_n    = rx_sh;
    byte_valid = 1'b0;
    stop_bad   = 1'b0;
    case (rx_st)
      RX_IDLE: begin
        if (!rxs) begin
          rx_st_n = RX_START;
          cnt_n   = '0;
        end
      end
      RX_START: begin
        if (cnt == HALF) begin
          if (rxs) begin
            rx_st_n = RX_IDLE;
          end else begin
            rx_st_n = RX_DATA;
            cnt_n   = '0;
            bit_i_n = '0;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt == LAST) begin
          cnt_n   = '0;
          rx_sh_n = {rxs, rx_sh[7:1]};
          bit_i_n = bit_i + 1'b1;
          if (bit_i == 3'd7) rx_st_n = RX_STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt == LAST) begin
          // Straight back to idle on the sample so a start bit that follows
          // immediately is not missed.
          byte_valid = rxs;
          stop_bad   = !rxs;
          rx_st_n    = RX_IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: rx_st_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_st     <= RX_IDLE;
      cnt       <= '0;
      bit_i     <= '0;
      rx_sh     <= '0;
      frame_err <= 1'b0;
    end else begin
      rx_st     <= rx_st_n;
      cnt       <= cnt_n;
      bit_i     <= bit_i_n;
      rx_sh     <= rx_sh_n;
      frame_err <= stop_bad;
    end
  end

  // ---------------------------------------------------------------- loader
  typedef enum logic [1:0] {LEN_HI, LEN_LO, WORD, DONE} ld_state_t;

  ld_state_t          ld_st, ld_st_n;
  logic [15:0]        len, len_n;
  logic [15:0]        wcnt, wcnt_n;
  logic [1:0]         bidx, bidx_n;
  logic [31:0]        asm_r, asm_n;
  logic               we_n;
  logic [ADDR_W-1:0]  addr_n;
  logic [31:0]        wdata_n;
  logic [31:0]        word_nxt;
  logic [15:0]        len_nxt;
  logic [15:0]        wcnt_inc;

  assign word_nxt = {asm_r[23:0], rx_sh};
  assign len_nxt  = {len[15:8], rx_sh};
  assign wcnt_inc = wcnt + 16'd1;

  always_comb begin
    ld_st_n = ld_st;
    len_n   = len;
    wcnt_n  = wcnt;
    bidx_n  = bidx;
    asm_n   = asm_r;
    we_n    = 1'b0;
    addr_n  = imem_addr;
    wdata_n = imem_wdata;
    if (byte_valid) begin
      case (ld_st)
        LEN_HI: begin
          len_n   = {rx_sh, 8'h00};
          ld_st_n = LEN_LO;
        end
        LEN_LO: begin
          len_n   = len_nxt;
          wcnt_n  = '0;
          bidx_n  = '0;
          ld_st_n = (len_nxt == 16'd0) ? DONE : WORD;
        end
        WORD: begin
          asm_n = word_nxt;
          if (bidx == 2'd3) begin
            we_n    = 1'b1;
            wdata_n = word_nxt;
            addr_n  = wcnt[ADDR_W-1:0];
            wcnt_n  = wcnt_inc;
            bidx_n  = '0;
            if (wcnt_inc == len) ld_st_n = DONE;
          end else begin
            bidx_n = bidx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_st      <= LEN_HI;
      len        <= '0;
      wcnt       <= '0;
      bidx       <= '0;
      asm_r      <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_rst    <= 1'b1;
      boot_done  <= 1'b0;
    end else begin
      ld_st      <= ld_st_n;
      len        <= len_n;
      wcnt       <= wcnt_n;
      bidx       <= bidx_n;
      asm_r      <= asm_n;
      imem_we    <= we_n;
      imem_addr  <= addr_n;
      imem_wdata <= wdata_n;
      // Follows the loader state one cycle late so release lands on the
      // cycle after the final write strobe.
      cpu_rst    <= (ld_st != DONE);
      boot_done  <= (ld_st == DONE);
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Testbench for uart_boot_loader (CLKS_PER_BIT=8, ADDR_W=4).
// Stimulus pushes each expected write into a queue; a negedge monitor pops
// and compares on every imem_we strobe and counts frame_err pulses.
module tb_uart_boot_loader;

  localparam int CPB = 8;
  localparam int AW  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rx  = 1'b1;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_rst;
  logic          boot_done;
  logic          frame_err;

  uart_boot_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .boot_done  (boot_done),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t exp_q[$];
  int  total = 0;
  int  bad   = 0;
  int  ferr_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (imem_we) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_we", 32'd1, 32'd0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("we_addr", 32'(imem_addr), 32'(e.addr));
          chk("we_data", imem_wdata, e.data);
        end
      end
      if (frame_err) ferr_cnt++;
    end
  end

  // Must be entered on a negedge; returns on a negedge 10 bit times later.
  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_ok;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_word(input logic [AW-1:0] a, input logic [31:0] w);
    wr_t e;
    e.addr = a;
    e.data = w;
    exp_q.push_back(e);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic send_hdr(input logic [15:0] n);
    send_byte(n[15:8], 1'b1);
    send_byte(n[7:0], 1'b1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_we"},    32'(imem_we),   32'd0);
    chk({tag, "_addr"},  32'(imem_addr), 32'd0);
    chk({tag, "_wdata"}, imem_wdata,     32'd0);
    chk({tag, "_cpurst"},32'(cpu_rst),   32'd1);
    chk({tag, "_bdone"}, 32'(boot_done), 32'd0);
    chk({tag, "_ferr"},  32'(frame_err), 32'd0);
  endtask

  task automatic reset_dut(input string tag);
    rx  = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_vals(tag);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Called right after the final byte of an image returns.
  task automatic chk_boot_after_we(input string tag);
    chk({tag, "_we_last"},  32'(imem_we),   32'd1);
    chk({tag, "_bd_early"}, 32'(boot_done), 32'd0);
    @(negedge clk);
    chk({tag, "_bd"},      32'(boot_done), 32'd1);
    chk({tag, "_cpurst"},  32'(cpu_rst),   32'd0);
  endtask

  initial begin
    int f0;
    #2;
    @(negedge clk);
    reset_dut("rst0");

    // Two-word image
    send_hdr(16'h0002);
    chk("a_cpurst_loading", 32'(cpu_rst), 32'd1);
    send_word(4'd0, 32'h2008_0005);
    send_word(4'd1, 32'h2009_000A);
    chk_boot_after_we("a");
    repeat (4) @(negedge clk);
    chk("a_bd_held", 32'(boot_done), 32'd1);

    // Reset after a completed load clears everything
    reset_dut("rst1");

    // Abort mid-transfer, then a fresh image loads from addr 0
    send_hdr(16'h0003);
    send_byte(8'hDE, 1'b1);
    send_byte(8'hAD, 1'b1);
    reset_dut("rst_mid");
    send_hdr(16'h0001);
    send_word(4'd0, 32'hDEAD_BEEF);
    chk_boot_after_we("mid");

    // Empty image
    reset_dut("rst2");
    send_byte(8'h00, 1'b1);
    rx = 1'b0;  // start bit of the low header byte, driven inside send_byte too
    send_byte(8'h00, 1'b1);
    chk("z_bd_early", 32'(boot_done), 32'd0);
    chk("z_cpurst_early", 32'(cpu_rst), 32'd1);
    @(negedge clk);
    chk("z_bd", 32'(boot_done), 32'd1);
    chk("z_cpurst", 32'(cpu_rst), 32'd0);

    // Glitch while idle, then a framing error inside a word
    reset_dut("rst3");
    send_hdr(16'h0001);
    f0 = ferr_cnt;
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    chk("glitch_no_ferr", 32'(ferr_cnt), 32'(f0));
    begin
      wr_t e;
      e.addr = 4'd0;
      e.data = 32'hA512_3456;
      exp_q.push_back(e);
    end
    send_byte(8'hA5, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    chk("ferr_one_pulse", 32'(ferr_cnt), 32'(f0 + 1));
    chk("ferr_no_done", 32'(boot_done), 32'd0);
    send_byte(8'h34, 1'b1);
    send_byte(8'h56, 1'b1);
    chk_boot_after_we("fe");

    // 17 words with ADDR_W=4: addr wraps, last write lands at 0
    reset_dut("rst4");
    send_hdr(16'h0011);
    for (int k = 0; k < 17; k++) begin
      logic [31:0] kw;
      kw = 32'(k);
      send_word(kw[AW-1:0], kw);
    end
    chk_boot_after_we("wrap");
    chk("wrap_last_addr", 32'(imem_addr), 32'd0);
    chk("wrap_last_data", imem_wdata, 32'h0000_0010);

    repeat (4) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard bound on simulated time
  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
